// File: rtl/controller_pkg.sv
// Shared types and encodings for the multicycle instruction controller.
package controller_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC,
    S_ALUWB,
    S_BRANCH,
    S_HALT
  } state_t;

  localparam logic [1:0] OP_DATA    = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BRANCH  = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [3:0] PC_REG = 4'b1011;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_REG = 1'b1;
  localparam logic ADR_PC   = 1'b0;
  localparam logic ADR_ALU  = 1'b1;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_write;
    logic       pc_write;
    logic       reg_write;
    logic       flag_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_control;
    logic [1:0] result_src;
    logic [1:0] imm_src;
    logic       halted;
  } ctrl_t;

endpackage

// File: rtl/retire_counter.sv
// Retired-instruction counter: synchronous clear, increment enable, natural wrap.
module retire_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples its inputs from before the edge, independent of block order.
  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle instruction-sequencing FSM: registered state, outputs decoded
// combinationally from state and current inputs, plus a retired counter.
module multicycle_controller
  import controller_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       op,
  input  logic [3:0]       funct,
  input  logic [3:0]       rd,
  input  logic             cond_ok,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic             reg_write,
  output logic             flag_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_control,
  output logic [1:0]       result_src,
  output logic [1:0]       imm_src,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  state_t state, state_next;
  ctrl_t  c;
  logic   retire;
  logic   dest_is_pc;
  logic   alu_wb_write;

  assign dest_is_pc   = (rd == PC_REG);
  assign alu_wb_write = cond_ok && (funct[3:2] != ALU_SUB);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_FETCH;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    c          = '0;
    retire     = 1'b0;
    // Instruction fields come from the IR, so they are meaningful after FETCH.
    if (state != S_FETCH) c.imm_src = op;

    unique case (state)
      S_FETCH: begin
        c.mem_req     = 1'b1;
        c.adr_src     = ADR_PC;
        c.alu_src_a   = SRCA_PC;
        c.alu_src_b   = SRCB_FOUR;
        c.alu_control = ALU_ADD;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        unique case (op)
          OP_MEM:    state_next = S_MEMADR;
          OP_DATA:   state_next = S_EXEC;
          OP_BRANCH: state_next = S_BRANCH;
          default:   state_next = S_HALT;
        endcase
      end
      S_MEMADR: begin
        c.alu_src_a   = SRCA_REG;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_ADD;
        state_next    = funct[1] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        c.mem_req = 1'b1;
        c.adr_src = ADR_ALU;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWR: begin
        c.mem_req = 1'b1;
        c.mem_we  = 1'b1;
        c.adr_src = ADR_ALU;
        if (mem_ready) begin
          state_next = S_FETCH;
          retire     = 1'b1;
        end
      end
      S_MEMWB: begin
        c.result_src = RES_MEM;
        c.reg_write  = cond_ok;
        c.pc_write   = cond_ok && dest_is_pc;
        state_next   = S_FETCH;
        retire       = 1'b1;
      end
      S_EXEC: begin
        c.alu_src_a   = SRCA_REG;
        c.alu_src_b   = funct[0] ? SRCB_IMM : SRCB_REG;
        // Immediate move passes the operand through the adder unchanged.
        c.alu_control = (funct[3:2] == ALU_OR && funct[0]) ? ALU_ADD : funct[3:2];
        state_next    = S_ALUWB;
      end
      S_ALUWB: begin
        c.result_src = RES_ALUOUT;
        c.flag_write = funct[1] && cond_ok;
        c.reg_write  = alu_wb_write;
        c.pc_write   = alu_wb_write && dest_is_pc;
        state_next   = S_FETCH;
        retire       = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a   = SRCA_PC;
        c.alu_src_b   = SRCB_IMM;
        c.alu_control = ALU_ADD;
        c.result_src  = RES_ALU;
        c.pc_write    = cond_ok;
        state_next    = S_FETCH;
        retire        = 1'b1;
      end
      S_HALT: begin
        c.halted = 1'b1;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase

    if (rst) begin
      c      = '0;
      retire = 1'b0;
    end
  end

  assign mem_req     = c.mem_req;
  assign mem_we      = c.mem_we;
  assign adr_src     = c.adr_src;
  assign ir_write    = c.ir_write;
  assign pc_write    = c.pc_write;
  assign reg_write   = c.reg_write;
  assign flag_write  = c.flag_write;
  assign alu_src_a   = c.alu_src_a;
  assign alu_src_b   = c.alu_src_b;
  assign alu_control = c.alu_control;
  assign result_src  = c.result_src;
  assign imm_src     = c.imm_src;
  assign halted      = c.halted;

  retire_counter #(.W(CNT_W)) u_retire_counter (
    .clk   (clk),
    .clr   (rst),
    .inc   (retire),
    .count (retired)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller; outputs are compared
// at the falling edge against hand-computed control vectors.
module tb_multicycle_controller;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       op;
  logic [3:0]       funct;
  logic [3:0]       rd;
  logic             cond_ok;
  logic             mem_ready;
  logic             mem_req, mem_we, adr_src, ir_write, pc_write;
  logic             reg_write, flag_write, alu_src_a, halted;
  logic [1:0]       alu_src_b, alu_control, result_src, imm_src;
  logic [CNT_W-1:0] retired;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .cond_ok     (cond_ok),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .adr_src     (adr_src),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .reg_write   (reg_write),
    .flag_write  (flag_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .alu_control (alu_control),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .halted      (halted),
    .retired     (retired)
  );

  // {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, flag_write,
  //  alu_src_a, alu_src_b, alu_control, result_src, imm_src, halted}
  wire [16:0] obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                     flag_write, alu_src_a, alu_src_b, alu_control, result_src,
                     imm_src, halted};

  function automatic logic [16:0] v(
    input logic mreq, input logic we, input logic adr, input logic irw,
    input logic pcw, input logic rw, input logic fw, input logic a,
    input logic [1:0] b, input logic [1:0] alu, input logic [1:0] res,
    input logic [1:0] imm, input logic h);
    return {mreq, we, adr, irw, pcw, rw, fw, a, b, alu, res, imm, h};
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, o, e);
  endtask

  // One cycle: compare controls at the falling edge, then step past the rising edge.
  task automatic cyc(input string tag, input logic [16:0] e);
    @(negedge clk);
    check(tag, 32'(obs), 32'(e));
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ret(input string tag, input logic [CNT_W-1:0] e);
    check(tag, 32'(retired), 32'(e));
  endtask

  localparam logic [16:0] V_ZERO = 17'd0;

  logic [16:0] v_fetch, v_fetch_wait;

  initial begin
    v_fetch      = v(1,0,0,1,1,0,0, 0,2'b10,2'b00,2'b00,2'b00,0);
    v_fetch_wait = v(1,0,0,0,0,0,0, 0,2'b10,2'b00,2'b00,2'b00,0);

    rst = 1'b1; op = 2'b00; funct = 4'b0000; rd = 4'b0000;
    cond_ok = 1'b1; mem_ready = 1'b1;
    tick();
    cyc("reset_outputs", V_ZERO);
    chk_ret("reset_retired", 4'd0);
    rst = 1'b0;

    // Data-process with immediate and set-flags
    op = 2'b00; funct = 4'b0011; rd = 4'b0010; cond_ok = 1'b1;
    cyc("data_fetch",  v_fetch);
    cyc("data_decode", V_ZERO);
    cyc("data_exec",   v(0,0,0,0,0,0,0, 1,2'b01,2'b00,2'b00,2'b00,0));
    chk_ret("data_retired_before", 4'd0);
    cyc("data_aluwb",  v(0,0,0,0,0,1,1, 0,2'b00,2'b00,2'b00,2'b00,0));
    chk_ret("data_retired_after", 4'd1);

    // Compare: flags only, no register write
    funct = 4'b0110;
    cyc("cmp_fetch",  v_fetch);
    cyc("cmp_decode", V_ZERO);
    cyc("cmp_exec",   v(0,0,0,0,0,0,0, 1,2'b00,2'b01,2'b00,2'b00,0));
    cyc("cmp_aluwb",  v(0,0,0,0,0,0,1, 0,2'b00,2'b00,2'b00,2'b00,0));
    chk_ret("cmp_retired", 4'd2);

    // Immediate move into PC: ALU forced to add, pc_write follows reg_write
    funct = 4'b1101; rd = 4'b1011;
    cyc("mov_fetch",  v_fetch);
    cyc("mov_decode", V_ZERO);
    cyc("mov_exec",   v(0,0,0,0,0,0,0, 1,2'b01,2'b00,2'b00,2'b00,0));
    cyc("mov_aluwb",  v(0,0,0,0,1,1,0, 0,2'b00,2'b00,2'b00,2'b00,0));
    chk_ret("mov_retired", 4'd3);

    // Load with two wait cycles in MEMRD: 7 cycles total
    op = 2'b01; funct = 4'b0011; rd = 4'b0010;
    cyc("ld_fetch",  v_fetch);
    cyc("ld_decode", v(0,0,0,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b01,0));
    cyc("ld_memadr", v(0,0,0,0,0,0,0, 1,2'b01,2'b00,2'b00,2'b01,0));
    mem_ready = 1'b0;
    cyc("ld_memrd_wait1", v(1,0,1,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b01,0));
    cyc("ld_memrd_wait2", v(1,0,1,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b01,0));
    mem_ready = 1'b1;
    cyc("ld_memrd_done",  v(1,0,1,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b01,0));
    chk_ret("ld_retired_before", 4'd3);
    cyc("ld_memwb",  v(0,0,0,0,0,1,0, 0,2'b00,2'b00,2'b01,2'b01,0));
    chk_ret("ld_retired_after", 4'd4);

    // Store interrupted by reset while waiting for memory
    funct = 4'b0000;
    cyc("st_fetch",  v_fetch);
    cyc("st_decode", v(0,0,0,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b01,0));
    cyc("st_memadr", v(0,0,0,0,0,0,0, 1,2'b01,2'b00,2'b00,2'b01,0));
    mem_ready = 1'b0;
    cyc("st_memwr_wait", v(1,1,1,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b01,0));
    rst = 1'b1;
    cyc("st_reset_outputs", V_ZERO);
    rst = 1'b0;
    chk_ret("st_reset_retired", 4'd0);
    cyc("st_refetch_wait", v_fetch_wait);
    cyc("st_refetch_hold", v_fetch_wait);
    mem_ready = 1'b1;

    // Store completing with no waits: 4 cycles
    cyc("st2_fetch",  v_fetch);
    cyc("st2_decode", v(0,0,0,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b01,0));
    cyc("st2_memadr", v(0,0,0,0,0,0,0, 1,2'b01,2'b00,2'b00,2'b01,0));
    cyc("st2_memwr",  v(1,1,1,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b01,0));
    chk_ret("st2_retired", 4'd1);

    // Branches: not taken still retires, taken writes PC
    op = 2'b10; funct = 4'b0000; cond_ok = 1'b0;
    cyc("br0_fetch",  v_fetch);
    cyc("br0_decode", v(0,0,0,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b10,0));
    cyc("br0_branch", v(0,0,0,0,0,0,0, 0,2'b01,2'b00,2'b10,2'b10,0));
    chk_ret("br0_retired", 4'd2);
    cond_ok = 1'b1;
    cyc("br1_fetch",  v_fetch);
    cyc("br1_decode", v(0,0,0,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b10,0));
    cyc("br1_branch", v(0,0,0,0,1,0,0, 0,2'b01,2'b00,2'b10,2'b10,0));
    chk_ret("br1_retired", 4'd3);

    // Counter wrap: 12 more branches reach all-ones, one more wraps to zero
    for (int i = 0; i < 36; i++) tick();
    chk_ret("wrap_all_ones", 4'd15);
    for (int i = 0; i < 3; i++) tick();
    chk_ret("wrap_zero", 4'd0);

    // Illegal op: HALT absorbs with no enables, reset recovers
    op = 2'b11;
    cyc("ill_fetch",  v_fetch);
    cyc("ill_decode", v(0,0,0,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b11,0));
    for (int i = 0; i < 10; i++) begin
      cyc($sformatf("halt_%0d", i), v(0,0,0,0,0,0,0, 0,2'b00,2'b00,2'b00,2'b11,1));
    end
    chk_ret("halt_retired", 4'd0);
    rst = 1'b1;
    cyc("halt_reset_outputs", V_ZERO);
    rst = 1'b0;
    chk_ret("halt_reset_retired", 4'd0);
    cyc("halt_refetch", v_fetch);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameter CNT_W, default 32: width of the retired-instruction counter.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 op  input  2  instruction class: 00 data-process, 01 memory, 10 branch, 11 illegal.
REQ-005 funct  input  4  [0]=immediate operand, [1]=load(mem)/set-flags(data), [3:2]=ALU op (00 add, 01 sub/compare, 10 and, 11 or/move).
REQ-006 rd  input  4  destination register; value 4'b1011 designates the PC.
REQ-007 cond_ok  input  1  condition-flag check result for the current instruction.
REQ-008 mem_ready  input  1  memory completes the current request this cycle.
REQ-009 mem_req  output  1  memory request valid; mem_we  output  1  request is a write.
REQ-010 adr_src  output  1  0 = PC address, 1 = ALU-result address.
REQ-011 ir_write, pc_write, reg_write, flag_write  output  1 each  register enables.
REQ-012 alu_src_a  output  1 (0 PC, 1 register); alu_src_b  output  2 (00 register, 01 immediate, 10 constant 4).
REQ-013 alu_control  output  2  ALU op; result_src  output  2 (00 ALU reg, 01 memory data, 10 ALU direct).
REQ-014 imm_src  output  2  immediate-extension select, equal to op in DECODE and later states.
REQ-015 halted  output  1  illegal op seen; retired  output  CNT_W  instructions completed.

Function
REQ-016 The block SHALL implement states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, HALT.
REQ-017 FETCH: mem_req=1, adr_src=0, alu_src_a=0, alu_src_b=10, alu_control=00; on mem_ready assert ir_write and pc_write in that same cycle and go to DECODE, else hold.
REQ-018 DECODE (1 cycle): op 01 -> MEMADR; op 00 -> EXEC; op 10 -> BRANCH; op 11 -> HALT.
REQ-019 MEMADR (1 cycle): alu_src_a=1, alu_src_b=01, alu_control=00; funct[1]=1 -> MEMRD, else -> MEMWR.
REQ-020 MEMRD: mem_req=1, adr_src=1; on mem_ready -> MEMWB. MEMWR: mem_req=1, mem_we=1, adr_src=1; on mem_ready -> FETCH (retire).
REQ-021 MEMWB (1 cycle): result_src=01, reg_write=cond_ok; pc_write=cond_ok when rd=1011; -> FETCH (retire).
REQ-022 EXEC (1 cycle): alu_src_a=1, alu_src_b = funct[0] ? 01 : 00; alu_control=funct[3:2], forced to 00 when funct[3:2]=11 and funct[0]=1 (move); -> ALUWB.
REQ-023 ALUWB (1 cycle): result_src=00; flag_write=funct[1]&cond_ok; reg_write=cond_ok unless funct[3:2]=01 (compare); pc_write=reg_write when rd=1011; -> FETCH (retire).
REQ-024 BRANCH (1 cycle): alu_src_a=0, alu_src_b=01, alu_control=00, result_src=10, pc_write=cond_ok; -> FETCH (retire).
REQ-025 HALT SHALL be absorbing until rst; halted=1; every enable and mem_req=0.
REQ-026 Outputs not listed for a state SHALL be 0; all outputs SHALL be decoded from registered state and current inputs only.
REQ-027 mem_req SHALL stay asserted with stable adr_src/mem_we until mem_ready; mem_ready outside FETCH/MEMRD/MEMWR SHALL be ignored.
REQ-028 op/funct/rd SHALL be sampled only in DECODE and later states; they are stable from the instruction register.
REQ-029 retired SHALL increment by 1 on each retire transition, also when cond_ok=0, and wrap from all-ones to 0.
REQ-030 Minimum latencies with mem_ready tied 1: data 4, branch 3, store 4, load 5 cycles.

Reset
REQ-031 rst=1 at a clock edge SHALL force state FETCH, retired=0, halted=0, even mid memory wait or from HALT.
REQ-032 While rst=1 all enables and mem_req SHALL be 0; FETCH begins the cycle after rst deasserts.

Structure
REQ-033 Shared package controller_pkg SHALL hold the state enum, op-class constants (OP_DATA, OP_MEM, OP_BRANCH), PC register index 4'b1011 and ALU/result/src-b select constants.
REQ-034 The counter SHALL be one sub-module, retire_counter (CNT_W wide, synchronous clear, increment enable).

Verification
REQ-035 Data: op=00 funct=0011 rd=0010 cond_ok=1, mem_ready=1 -> state sequence FETCH,DECODE,EXEC,ALUWB; ALUWB reg_write=1, flag_write=1, alu_src_b=01; retired 0->1.
REQ-036 Compare: op=00 funct=0110 -> ALUWB reg_write=0, flag_write=1, alu_control=01.
REQ-037 Load with waits: op=01 funct=0011, mem_ready low 2 cycles in MEMRD -> mem_req/adr_src=1 held 3 cycles, then MEMWB reg_write=1, result_src=01; 7 cycles total.
REQ-038 Branch, cond_ok=0 -> BRANCH pc_write=0, retired still increments; cond_ok=1 -> pc_write=1, result_src=10.
REQ-039 Illegal op=11 -> HALT, halted=1, no enables for 10 cycles; rst pulse -> FETCH, retired=0.
REQ-040 rst asserted during MEMWR wait -> next cycle FETCH, mem_we=0, no store completed.
